// File: rtl/beat_sequencer_if.sv
// Beat sequencer control/strobe bundle.
//  master: the sequencer (drives strobes, beat flags, counters, status; samples run/step/stop)
//  slave : store/accumulator side and front panel (drives run/step/stop; samples the rest)
interface beat_sequencer_if #(
  parameter int unsigned TUBE_DEPTH     = 32,
  parameter int unsigned N_ACTION_BEATS = 4
);
  localparam int unsigned BEAT_W = (N_ACTION_BEATS > 1) ? $clog2(N_ACTION_BEATS) : 1;
  localparam int unsigned CNT_W  = (TUBE_DEPTH > 1) ? $clog2(TUBE_DEPTH) : 1;

  logic              w_RUN;
  logic              w_STEP;
  logic              w_STOP_REQ;
  logic              ready_out;
  logic              ready_in;
  logic              w_HS;
  logic              w_ACTION;
  logic [BEAT_W-1:0] b_BEAT;
  logic [CNT_W-1:0]  b_SCAN_CNT;
  logic              w_FRAME;
  logic              w_INSTR_END;
  logic              w_HALTED;

  modport master (
    input  w_RUN, w_STEP, w_STOP_REQ,
    output ready_out, ready_in, w_HS, w_ACTION, b_BEAT, b_SCAN_CNT,
           w_FRAME, w_INSTR_END, w_HALTED
  );

  modport slave (
    output w_RUN, w_STEP, w_STOP_REQ,
    input  ready_out, ready_in, w_HS, w_ACTION, b_BEAT, b_SCAN_CNT,
           w_FRAME, w_INSTR_END, w_HALTED
  );
endinterface

// File: rtl/beat_sequencer.sv
// Beat timing generator for the main store and accumulator. Interleaves one scan
// (regeneration) beat with each action beat; N_ACTION_BEATS action beats form one
// instruction. While halted only scan beats run.
//  w_CLK : system clock, rising edge
//  w_RST : asynchronous reset, active-high
//  bus   : master side of beat_sequencer_if (run/step/stop in; strobes, beat flags,
//          beat index, scan count, frame/instruction-end pulses, halted status out)
module beat_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 1,
  parameter int unsigned TUBE_DEPTH     = 32,
  parameter int unsigned N_ACTION_BEATS = 4
) (
  input logic              w_CLK,
  input logic              w_RST,
  beat_sequencer_if.master bus
);
  localparam int unsigned BEAT_W = (N_ACTION_BEATS > 1) ? $clog2(N_ACTION_BEATS) : 1;
  localparam int unsigned CNT_W  = (TUBE_DEPTH > 1) ? $clog2(TUBE_DEPTH) : 1;
  localparam int unsigned PH_W   = $clog2(SETTLE_CYCLES + 2);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SETTLE_CYCLES + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N_ACTION_BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TUBE_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              active_q, active_d;       // 0 only until the first beat starts
  logic [PH_W-1:0]   ph_q, ph_d;               // cycle index within the current beat
  logic              in_instr_q, in_instr_d;   // an instruction has started and not ended
  logic              step_pend_q, step_d;
  logic              stop_pend_q, stop_d;
  logic              ready_out_q, ready_out_d;
  logic              ready_in_q, ready_in_d;
  logic              hs_q, hs_d;
  logic              action_q, action_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_q, frame_d;
  logic              instr_end_q, instr_end_d;
  logic              halted_q, halted_d;
  logic              in_cyc, scan_in, instr_done;

  // State and output registers
  always_ff @(posedge w_CLK or posedge w_RST) begin
    if (w_RST) begin
      state_q     <= ST_HALT;
      active_q    <= 1'b0;
      ph_q        <= '0;
      in_instr_q  <= 1'b0;
      step_pend_q <= 1'b0;
      stop_pend_q <= 1'b0;
      ready_out_q <= 1'b0;
      ready_in_q  <= 1'b0;
      hs_q        <= 1'b0;
      action_q    <= 1'b0;
      beat_q      <= '0;
      cnt_q       <= '0;
      frame_q     <= 1'b0;
      instr_end_q <= 1'b0;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      ph_q        <= ph_d;
      in_instr_q  <= in_instr_d;
      step_pend_q <= step_d;
      stop_pend_q <= stop_d;
      ready_out_q <= ready_out_d;
      ready_in_q  <= ready_in_d;
      hs_q        <= hs_d;
      action_q    <= action_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      instr_end_q <= instr_end_d;
      halted_q    <= halted_d;
    end
  end

  // Next-state and next-output logic; registered values describe the coming cycle
  always_comb begin
    state_d     = state_q;
    active_d    = 1'b1;
    ph_d        = '0;
    in_instr_d  = in_instr_q;
    hs_d        = hs_q;
    action_d    = action_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    frame_d     = 1'b0;
    instr_end_d = 1'b0;

    in_cyc     = active_q && (ph_q == PH_LAST);
    scan_in    = in_cyc && hs_q;
    instr_done = in_cyc && action_q && (beat_q == BEAT_LAST);

    step_d = step_pend_q | bus.w_STEP;
    stop_d = stop_pend_q | ((state_q != ST_HALT) && bus.w_STOP_REQ);

    // Run control is only evaluated at beat/instruction boundaries
    unique case (state_q)
      ST_HALT: begin
        if (scan_in) begin
          if (bus.w_RUN) begin
            state_d = ST_RUN;
          end else if (step_pend_q) begin
            state_d = ST_STEP;
            step_d  = bus.w_STEP;   // a step arriving this very cycle is kept
          end
        end
      end
      ST_RUN: begin
        if (instr_done && (!bus.w_RUN || stop_d)) state_d = ST_HALT;
      end
      ST_STEP: begin
        if (instr_done) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase

    if (instr_done) begin
      stop_d     = 1'b0;
      in_instr_d = 1'b0;
    end

    if (active_q && (ph_q != PH_LAST)) ph_d = ph_q + 1'b1;

    // Beat type is decided at the OUT cycle using the post-transition state
    if (ph_d == '0) begin
      if (hs_q && (state_d != ST_HALT)) begin
        hs_d       = 1'b0;
        action_d   = 1'b1;
        beat_d     = in_instr_q ? beat_q + 1'b1 : '0;
        in_instr_d = 1'b1;
      end else begin
        hs_d     = 1'b1;
        action_d = 1'b0;
      end
    end

    ready_out_d = (ph_d == '0);
    ready_in_d  = (ph_d == PH_LAST);

    // Scan count advances with the IN strobe of each scan beat
    if (ready_in_d && hs_d) begin
      frame_d = (cnt_q == CNT_LAST);
      cnt_d   = frame_d ? '0 : cnt_q + 1'b1;
    end

    instr_end_d = instr_done;
    halted_d    = (state_d == ST_HALT);
  end

  assign bus.ready_out   = ready_out_q;
  assign bus.ready_in    = ready_in_q;
  assign bus.w_HS        = hs_q;
  assign bus.w_ACTION    = action_q;
  assign bus.b_BEAT      = beat_q;
  assign bus.b_SCAN_CNT  = cnt_q;
  assign bus.w_FRAME     = frame_q;
  assign bus.w_INSTR_END = instr_end_q;
  assign bus.w_HALTED    = halted_q;
endmodule
